data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressable data memory for the MIPS datapath (MEM stage).
- Supports word, halfword and byte loads/stores, selected by MemType.
- Writes are synchronous; reads are combinational.
- Sits between the ALU address output and the write-back mux.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array.
- ADDR_BITS, 10, word-index width; must equal log2(DEPTH).

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  synchronous, active-high reset.
- Address  input  32  byte address from the ALU.
- WriteData  input  32  store data; the low byte or halfword is used for sb/sh.
- MemWrite  input  1  store enable, sampled at the rising edge.
- MemRead  input  1  load enable.
- MemType  input  2  access size: 00 = byte, 01 = halfword, 11 = word, 10 = word (reserved alias).
- ReadData  output  32  load result.

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high.
- Storage: DEPTH x 32-bit array.
  - Word index = Address[ADDR_BITS+1:2].
  - Byte offset = Address[1:0].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Byte lanes are little-endian within a word:
  - offset 0 = bits[7:0], 1 = [15:8], 2 = [23:16], 3 = [31:24].
  - Halfword: Address[1]=0 selects [15:0]; Address[1]=1 selects [31:16]. Address[0] is ignored.
  - Word: Address[1:0] is ignored.
- Misaligned accesses are not trapped.
- Reset: on a rising edge with Rst=1, every word is cleared to 0. Reset has priority over MemWrite, so a store in that cycle is dropped.
- Store, on a rising edge with Rst=0 and MemWrite=1:
  - word: the full word is written.
  - halfword: WriteData[15:0] is written to the selected half; the other half is unchanged.
  - byte: WriteData[7:0] is written to the selected lane; the other lanes are unchanged.
- Load (combinational, zero-cycle latency):
  - When MemRead=1, ReadData reflects the current array contents and updates immediately when Address or MemType changes.
  - word: full word.
  - halfword: selected half, sign-extended to 32 bits.
  - byte: selected byte, sign-extended to 32 bits.
  - When MemRead=0, ReadData = 32'h0.
- Reset values: there are no output registers. After reset, ReadData = 0 for any load, since all words are zero.
- MemRead and MemWrite both high in the same cycle: ReadData shows the old contents until the edge, then the newly written value.
- MemType X/Z during a store is not allowed. Benches must drive MemType=11 for word stores.

Test Plan:
- Reset: Rst=1 for one edge, then MemRead=1, MemType=11 at any address -> ReadData=32'h00000000.
- Word store/load: MemType=11, MemWrite=1, Address=32'h1C5D0F0A, WriteData=32'hAA6332A4, one edge. Then MemRead=1, MemWrite=0 -> ReadData=32'hAA6332A4.
- Halfword load from the same address (MemType=01, Address[1]=1) -> ReadData=32'hFFFFAA63, sign-extended.
- Byte load from the same address (MemType=00, offset 2) -> ReadData=32'h00000063. At offset 3 -> 32'hFFFFFFAA.
- Byte store MemType=00, Address=32'h1C5D0F08, WriteData=32'h000000FF, then word load of the same word -> ReadData=32'hAA6332FF. Then a halfword store of 32'h1234 at offset 2 -> word reads 32'h123432FF.
- Priority and wrap:
  - Rst=1 together with MemWrite=1 -> the word stays 0.
  - MemRead=0 -> ReadData=0.
  - Address 32'h00001000 aliases to word 0 (DEPTH=1024).

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressable data memory for the MEM stage.
// Synchronous little-endian stores, combinational sign-extending loads.
module data_memory #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  MemType,
    output logic [31:0] ReadData
);

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] index;
    logic [1:0]           offset;
    logic [31:0]          word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic                 unused_addr_bits;

    assign index  = Address[ADDR_BITS+1:2];
    assign offset = Address[1:0];
    assign word   = mem[index];

    // Upper address bits alias onto the array; they carry no meaning here.
    assign unused_addr_bits = ^Address[31:ADDR_BITS+2];

    // Storage update: reset clears every word and wins over a store.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            case (MemType)
                2'b00: begin
                    case (offset)
                        2'd0:    mem[index][7:0]   <= WriteData[7:0];
                        2'd1:    mem[index][15:8]  <= WriteData[7:0];
                        2'd2:    mem[index][23:16] <= WriteData[7:0];
                        default: mem[index][31:24] <= WriteData[7:0];
                    endcase
                end
                2'b01: begin
                    if (offset[1]) begin
                        mem[index][31:16] <= WriteData[15:0];
                    end else begin
                        mem[index][15:0] <= WriteData[15:0];
                    end
                end
                default: mem[index] <= WriteData;
            endcase
        end
    end

    // Lane selection for sub-word loads.
    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Load result: sign-extended sub-words, zero when not reading.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            case (MemType)
                2'b00:   ReadData = {{24{byte_sel[7]}}, byte_sel};
                2'b01:   ReadData = {{16{half_sel[15]}}, half_sel};
                default: ReadData = word;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expected load results,
// a monitor on the falling edge pops and compares them.
module tb_data_memory;

    logic        Clk;
    logic        Rst;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  MemType;
    logic [31:0] ReadData;

    logic [31:0] exp_q  [$];
    string       name_q [$];
    int          vectors;
    int          miscompares;

    data_memory #(
        .DEPTH(1024),
        .ADDR_BITS(10)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .MemType(MemType),
        .ReadData(ReadData)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: one expected value per cycle, checked away from the edge.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                vectors++;
                if (ReadData !== e) begin
                    miscompares++;
                    $display("FAIL %s: ReadData=%h expected %h",
                             n, ReadData, e);
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [1:0] t,
                         input logic [31:0] d);
        @(posedge Clk);
        #1;
        Rst       = 1'b0;
        Address   = a;
        MemType   = t;
        WriteData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
    endtask

    task automatic load(input logic rd, input logic [31:0] a,
                        input logic [1:0] t, input logic [31:0] exp,
                        input string n);
        @(posedge Clk);
        #1;
        Rst      = 1'b0;
        Address  = a;
        MemType  = t;
        MemWrite = 1'b0;
        MemRead  = rd;
        exp_q.push_back(exp);
        name_q.push_back(n);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst         = 1'b1;
        Address     = 32'h0;
        WriteData   = 32'h0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        MemType     = 2'b11;

        load(1, 32'h0000_0000, 2'b11, 32'h0000_0000, "reset_w0");
        load(1, 32'h1C5D_0F0A, 2'b11, 32'h0000_0000, "reset_w3c2");
        load(1, 32'h0000_0FFC, 2'b11, 32'h0000_0000, "reset_wlast");

        store(32'h1C5D_0F0A, 2'b11, 32'hAA63_32A4);
        load(1, 32'h1C5D_0F0A, 2'b11, 32'hAA63_32A4, "lw");
        load(1, 32'h1C5D_0F0A, 2'b01, 32'hFFFF_AA63, "lh_hi");
        load(1, 32'h1C5D_0F08, 2'b01, 32'h0000_32A4, "lh_lo");
        load(1, 32'h1C5D_0F09, 2'b01, 32'h0000_32A4, "lh_a0_ignored");
        load(1, 32'h1C5D_0F0A, 2'b00, 32'h0000_0063, "lb_off2");
        load(1, 32'h1C5D_0F0B, 2'b00, 32'hFFFF_FFAA, "lb_off3");
        load(1, 32'h1C5D_0F08, 2'b00, 32'hFFFF_FFA4, "lb_off0");
        load(1, 32'h1C5D_0F09, 2'b00, 32'h0000_0032, "lb_off1");
        load(1, 32'h1C5D_0F09, 2'b10, 32'hAA63_32A4, "lw_alias10");

        store(32'h1C5D_0F08, 2'b00, 32'h0000_00FF);
        load(1, 32'h1C5D_0F08, 2'b11, 32'hAA63_32FF, "sb_off0");
        store(32'h1C5D_0F0A, 2'b01, 32'h0000_1234);
        load(1, 32'h1C5D_0F08, 2'b11, 32'h1234_32FF, "sh_off2");
        store(32'h1C5D_0F08, 2'b01, 32'hFFFF_8001);
        load(1, 32'h1C5D_0F08, 2'b11, 32'h1234_8001, "sh_off0");
        load(1, 32'h1C5D_0F08, 2'b01, 32'hFFFF_8001, "lh_neg");
        store(32'h1C5D_0F0B, 2'b00, 32'h1234_5677);
        load(1, 32'h1C5D_0F08, 2'b11, 32'h7734_8001, "sb_off3");
        load(0, 32'h1C5D_0F08, 2'b11, 32'h0000_0000, "memread_0");

        store(32'h0000_1000, 2'b11, 32'hDEAD_BEEF);
        load(1, 32'h0000_0000, 2'b11, 32'hDEAD_BEEF, "wrap_w0");
        load(1, 32'h8000_1000, 2'b11, 32'hDEAD_BEEF, "wrap_hi");
        store(32'h0000_0FFC, 2'b11, 32'h1122_3344);
        load(1, 32'h0000_1FFC, 2'b11, 32'h1122_3344, "wrap_wlast");

        // Read and write together: old value before the edge, new after.
        @(posedge Clk);
        #1;
        Address   = 32'h0000_0010;
        MemType   = 2'b11;
        WriteData = 32'hCAFE_F00D;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        exp_q.push_back(32'h0000_0000);
        name_q.push_back("rw_old");
        load(1, 32'h0000_0010, 2'b11, 32'hCAFE_F00D, "rw_new");

        // Reset asserted together with a store: store dropped, all cleared.
        @(posedge Clk);
        #1;
        Rst       = 1'b1;
        Address   = 32'h0000_0020;
        MemType   = 2'b11;
        WriteData = 32'h5A5A_5A5A;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        load(1, 32'h0000_0020, 2'b11, 32'h0000_0000, "rst_prio");
        load(1, 32'h1C5D_0F08, 2'b11, 32'h0000_0000, "rst_clear");
        load(1, 32'h0000_0000, 2'b11, 32'h0000_0000, "rst_clear_w0");
        load(1, 32'h0000_0010, 2'b11, 32'h0000_0000, "rst_clear_rw");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge Clk);
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d pending, required 0", exp_q.size());
        end
        @(posedge Clk);
        MemRead = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
